// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed driver for a common-anode 7-segment bank.
// Double-buffered hex value with frame-aligned update, leading-zero blanking
// and per-digit blink. All outputs come straight from flops.
module hex_display_scan #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_blank,
  output logic [7:0]              hex_seg,
  output logic [NUM_DIGITS-1:0]   hex_an,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc_reg;
  logic [VW-1:0]         shadow_value_reg;
  logic [NUM_DIGITS-1:0] shadow_dp_reg;
  logic [NUM_DIGITS-1:0] shadow_blink_reg;
  logic [VW-1:0]         disp_value_reg;
  logic [NUM_DIGITS-1:0] disp_dp_reg;
  logic [NUM_DIGITS-1:0] disp_blink_reg;
  logic [FW-1:0]         frame_cnt_reg;
  logic                  blink_phase_reg;

  logic                  slot_end;
  logic                  last_digit;
  logic [VW-1:0]         disp_value_next;
  logic [NUM_DIGITS-1:0] disp_dp_next;
  logic [NUM_DIGITS-1:0] disp_blink_next;
  logic                  blink_phase_next;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Active-low glyph table for one hex nibble (segments g..a)
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  endfunction

  assign slot_end   = (presc_reg == PW'(SCAN_DIV - 1));
  assign last_digit = (digit_idx == IW'(NUM_DIGITS - 1));

  // Scan timing: prescaler, digit counter and the frame-wrap pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg  <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= slot_end && last_digit;
      if (slot_end) begin
        presc_reg <= '0;
        digit_idx <= last_digit ? '0 : digit_idx + IW'(1);
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  // Display contents that take effect this frame boundary (load bypasses the shadow)
  always_comb begin
    disp_value_next = disp_value_reg;
    disp_dp_next    = disp_dp_reg;
    disp_blink_next = disp_blink_reg;
    if (frame_done) begin
      if (load) begin
        disp_value_next = value;
        disp_dp_next    = dp;
        disp_blink_next = blink_mask;
      end else if (pending) begin
        disp_value_next = shadow_value_reg;
        disp_dp_next    = shadow_dp_reg;
        disp_blink_next = shadow_blink_reg;
      end
    end
  end

  // Shadow capture, display update and pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      shadow_blink_reg <= '0;
      disp_value_reg   <= '0;
      disp_dp_reg      <= '0;
      disp_blink_reg   <= '0;
      pending          <= 1'b0;
    end else begin
      if (load) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp;
        shadow_blink_reg <= blink_mask;
      end
      disp_value_reg <= disp_value_next;
      disp_dp_reg    <= disp_dp_next;
      disp_blink_reg <= disp_blink_next;
      if (frame_done)
        pending <= 1'b0;
      else if (load)
        pending <= 1'b1;
    end
  end

  assign blink_phase_next = (frame_done && frame_cnt_reg == FW'(BLINK_FRAMES - 1)) ?
                            ~blink_phase_reg : blink_phase_reg;

  // Blink timebase: count frames, flip phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      blink_phase_reg <= blink_phase_next;
      if (frame_done)
        frame_cnt_reg <= (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt_reg + FW'(1);
    end
  end

  // Split the effective display word into per-digit nibbles
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = disp_value_next[4*gi +: 4];
  end

  // Leading-zero mask: run of zero nibbles from the top digit, digit 0 excluded
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (nib[i] == 4'h0);
      lz_mask[i] = lz_blank && zero_run;
    end
  end

  // Segment/anode pattern for the digit being scanned
  always_comb begin
    seg_next = 8'hFF;
    an_next  = '1;
    if (!(blink_phase_next && disp_blink_next[digit_idx])) begin
      an_next[digit_idx] = 1'b0;
      seg_next[7]        = ~disp_dp_next[digit_idx];
      seg_next[6:0]      = lz_mask[digit_idx] ? 7'h7F : glyph(nib[digit_idx]);
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_seg <= 8'hFF;
      hex_an  <= '1;
    end else begin
      hex_seg <= seg_next;
      hex_an  <= an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan (6 digits, 4 clk per slot, 2 frames per blink half).
// Stimulus queues expected values tagged with the clock cycle they must appear on;
// the monitor compares them when that cycle is presented.
module tb_hex_display_scan;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [23:0] value;
  logic [5:0]  dp;
  logic [5:0]  blink_mask;
  logic        lz_blank;
  logic [7:0]  hex_seg;
  logic [5:0]  hex_an;
  logic [2:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  hex_display_scan #(.NUM_DIGITS(6), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .blink_mask (blink_mask),
    .lz_blank   (lz_blank),
    .hex_seg    (hex_seg),
    .hex_an     (hex_an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .pending    (pending)
  );

  localparam int S_SEG = 0, S_AN = 1, S_IDX = 2, S_FD = 3, S_PEND = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;
  int          cyc;
  int          base;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter: at a negedge it equals the number of posedges so far
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation at cycle base+k, kept sorted by cycle
  task automatic expect_at(input int k, input int sel, input logic [31:0] v, input string nm);
    exp_t n;
    int   i;
    n.cyc  = base + k;
    n.sel  = sel;
    n.val  = v;
    n.name = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > n.cyc) i--;
    q.insert(i, n);
  endtask

  // Expected seg/anode of one digit slot (sampled mid-slot of frame m)
  task automatic expect_digit(input int m, input int d, input logic [7:0] seg,
                              input logic [5:0] an, input string nm);
    expect_at(24*m + 4*d + 2, S_SEG, {24'h0, seg}, {nm, "_seg"});
    expect_at(24*m + 4*d + 2, S_AN,  {26'h0, an},  {nm, "_an"});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] d, input logic [5:0] b);
    value      = v;
    dp         = d;
    blink_mask = b;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor: compare every expectation due at the presented cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.sel)
        S_SEG:   act = {24'h0, hex_seg};
        S_AN:    act = {26'h0, hex_an};
        S_IDX:   act = {29'h0, digit_idx};
        S_FD:    act = {31'h0, frame_done};
        default: act = {31'h0, pending};
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s missed cycle %0d (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s cyc %0d got %0h expected %0h", e.name, cyc, act, e.val);
      end else begin
        $display("check %s cyc %0d value %0h ok", e.name, cyc, act);
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    base       = 0;
    reset_n    = 1'b0;
    load       = 1'b0;
    value      = '0;
    dp         = '0;
    blink_mask = '0;
    lz_blank   = 1'b0;

    // Reset state
    expect_at(1, S_SEG,  32'hFF, "rst_seg");
    expect_at(1, S_AN,   32'h3F, "rst_an");
    expect_at(1, S_IDX,  32'h0,  "rst_idx");
    expect_at(1, S_FD,   32'h0,  "rst_fd");
    expect_at(1, S_PEND, 32'h0,  "rst_pend");
    wait_cyc(3);
    #1 reset_n = 1'b1;
    base = cyc;

    // 1: scan timing and reset display of zeros
    expect_at(3,  S_IDX, 32'd0, "t1_idx3");
    expect_at(4,  S_IDX, 32'd1, "t1_idx4");
    expect_at(23, S_IDX, 32'd5, "t1_idx23");
    expect_at(24, S_IDX, 32'd0, "t1_idx24");
    expect_at(23, S_FD,  32'd0, "t1_fd23");
    expect_at(24, S_FD,  32'd1, "t1_fd24");
    expect_at(25, S_FD,  32'd0, "t1_fd25");
    expect_at(48, S_FD,  32'd1, "t1_fd48");
    expect_at(1,  S_SEG, 32'hC0, "t1_seg1");
    expect_at(1,  S_AN,  32'h3E, "t1_an1");
    expect_at(5,  S_AN,  32'h3D, "t1_an5");
    expect_at(21, S_AN,  32'h1F, "t1_an21");
    expect_at(24, S_AN,  32'h1F, "t1_an24");
    expect_at(25, S_AN,  32'h3E, "t1_an25");
    expect_digit(0, 2, 8'hC0, 6'h3B, "t1_d2");
    expect_digit(0, 5, 8'hC0, 6'h1F, "t1_d5");

    // 2: load 00012A with leading-zero blanking, shown from frame 2
    wait_cyc(base + 30);
    expect_at(31, S_PEND, 32'd1, "t2_pend31");
    expect_at(48, S_PEND, 32'd1, "t2_pend48");
    expect_at(49, S_PEND, 32'd0, "t2_pend49");
    expect_digit(2, 0, 8'h88, 6'h3E, "t2_d0");
    expect_digit(2, 1, 8'hA4, 6'h3D, "t2_d1");
    expect_digit(2, 2, 8'hF9, 6'h3B, "t2_d2");
    expect_digit(2, 3, 8'hFF, 6'h37, "t2_d3");
    expect_digit(2, 5, 8'hFF, 6'h1F, "t2_d5");
    lz_blank = 1'b1;
    do_load(24'h00012A, 6'h00, 6'h00);

    // 3: load 111111 while digit 3 is scanned; old value holds to frame end
    wait_cyc(base + 61);
    expect_at(62, S_PEND, 32'd1, "t3_pend62");
    expect_at(72, S_PEND, 32'd1, "t3_pend72");
    expect_at(73, S_PEND, 32'd0, "t3_pend73");
    expect_digit(2, 4, 8'hFF, 6'h2F, "t3_old_d4");
    expect_digit(2, 5, 8'hFF, 6'h1F, "t3_old_d5");
    expect_digit(3, 0, 8'hF9, 6'h3E, "t3_d0");
    expect_digit(3, 5, 8'hF9, 6'h1F, "t3_d5");
    do_load(24'h111111, 6'h00, 6'h00);

    // 4: load FFFFFF on the frame_done cycle goes straight to display
    wait_cyc(base + 96);
    expect_at(97, S_SEG,  32'h8E, "t4_seg97");
    expect_at(97, S_PEND, 32'd0,  "t4_pend97");
    expect_at(98, S_PEND, 32'd0,  "t4_pend98");
    expect_digit(4, 0, 8'h8E, 6'h3E, "t4_d0");
    expect_digit(4, 5, 8'h8E, 6'h1F, "t4_d5");
    do_load(24'hFFFFFF, 6'h00, 6'h00);

    // 5: blink digit 0; phase per frame m is (m/2)%2
    wait_cyc(base + 100);
    expect_at(101, S_PEND, 32'd1, "t5_pend101");
    expect_digit(5, 0, 8'h8E, 6'h3E, "t5_f5_vis");
    expect_digit(6, 0, 8'hFF, 6'h3F, "t5_f6_blank");
    expect_digit(6, 1, 8'h8E, 6'h3D, "t5_f6_d1");
    expect_digit(7, 0, 8'hFF, 6'h3F, "t5_f7_blank");
    expect_digit(8, 0, 8'h8E, 6'h3E, "t5_f8_vis");
    expect_digit(9, 0, 8'h8E, 6'h3E, "t5_f9_vis");
    do_load(24'hFFFFFF, 6'h00, 6'h01);

    // 6: all-zero value with dp on digit 0, then reset mid-slot
    wait_cyc(base + 220);
    expect_digit(10, 0, 8'h40, 6'h3E, "t6_d0");
    expect_digit(10, 1, 8'hFF, 6'h3D, "t6_d1");
    expect_digit(10, 5, 8'hFF, 6'h1F, "t6_d5");
    do_load(24'h000000, 6'h01, 6'h00);
    wait_cyc(base + 266);
    expect_at(267, S_PEND, 32'd1,  "t6_pend267");
    expect_at(267, S_SEG,  32'h40, "t6_seg267");
    expect_at(269, S_SEG,  32'hFF, "t6_rst_seg");
    expect_at(269, S_AN,   32'h3F, "t6_rst_an");
    expect_at(269, S_IDX,  32'd0,  "t6_rst_idx");
    expect_at(269, S_PEND, 32'd0,  "t6_rst_pend");
    do_load(24'h123456, 6'h00, 6'h00);
    wait_cyc(base + 268);
    @(posedge clk);
    #1 reset_n = 1'b0;
    wait_cyc(base + 272);
    #1 reset_n = 1'b1;
    base = cyc;

    // Shadow and pending lost across reset: display stays zero
    expect_at(2, S_PEND, 32'd0, "t6_post_pend2");
    expect_at(25, S_PEND, 32'd0, "t6_post_pend25");
    expect_digit(0, 0, 8'hC0, 6'h3E, "t6_post_f0d0");
    expect_digit(0, 3, 8'hFF, 6'h37, "t6_post_f0d3");
    expect_digit(1, 0, 8'hC0, 6'h3E, "t6_post_f1d0");
    expect_digit(1, 2, 8'hFF, 6'h3B, "t6_post_f1d2");

    wait_cyc(base + 40);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d expectations left, first %s", q.size(), q[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
